// File: rtl/multi_lane_instruction_queue_if.sv
// Fetch-to-decode bus for multi_lane_instruction_queue: producer (fetch) and
// consumer (decode) signals grouped together; the queue takes the slave modport.
interface multi_lane_instruction_queue_if #(
    parameter int LANES      = 3,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = $clog2(LANES + 1);

    logic [LANES-1:0]            in_valid_i;
    logic [LANES*DATA_WIDTH-1:0] in_instr_i;
    logic [LANES*DATA_WIDTH-1:0] in_pc_i;
    logic [LANES*DATA_WIDTH-1:0] in_imm_i;
    logic [LANES-1:0]            in_bp_i;
    logic                        in_ready_o;
    logic [LANES-1:0]            out_valid_o;
    logic [LANES*DATA_WIDTH-1:0] out_instr_o;
    logic [LANES*DATA_WIDTH-1:0] out_pc_o;
    logic [LANES*DATA_WIDTH-1:0] out_imm_o;
    logic [LANES-1:0]            out_bp_o;
    logic [CNT_WIDTH-1:0]        out_consume_i;
    logic                        flush_i;
    logic [ADDR_WIDTH:0]         count_o;
    logic                        empty_o;
    logic                        full_o;

    modport master (
        output in_valid_i, in_instr_i, in_pc_i, in_imm_i, in_bp_i,
        output out_consume_i, flush_i,
        input  in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_imm_o, out_bp_o,
        input  count_o, empty_o, full_o
    );

    modport slave (
        input  in_valid_i, in_instr_i, in_pc_i, in_imm_i, in_bp_i,
        input  out_consume_i, flush_i,
        output in_ready_o, out_valid_o, out_instr_o, out_pc_o, out_imm_o, out_bp_o,
        output count_o, empty_o, full_o
    );
endinterface

// File: rtl/multi_lane_instruction_queue.sv
// Multi-lane instruction queue: compacts sparse fetch groups, presents the oldest
// LANES entries to decode. Macros: IBUF_BYPASS_EN (same-cycle bypass), DEBUG (assertions).
module multi_lane_instruction_queue #(
    parameter int LANES      = 3,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic reset,
    multi_lane_instruction_queue_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = $clog2(LANES + 1);
    localparam int CW         = ADDR_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] imm_mem   [DEPTH];
    logic                  bp_mem    [DEPTH];

    logic [ADDR_WIDTH-1:0] rptr_reg, rptr_next, wptr_reg, wptr_next;
    logic [CW-1:0]         count_reg, count_next, free_cnt;
    logic                  in_ready, write_fire, bypass;
    logic [CNT_WIDTH-1:0]  lane_off [LANES];
    logic [CNT_WIDTH-1:0]  pop_in, wr_cnt, rd_cnt, avail, skip;
    logic [LANES-1:0]      wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr [LANES];

    logic [LANES-1:0]            out_valid;
    logic [LANES*DATA_WIDTH-1:0] out_instr, out_pc, out_imm;
    logic [LANES-1:0]            out_bp;

    // Admission looks only at the registered count so ready never depends on decode.
    assign free_cnt   = CW'(DEPTH) - count_reg;
    assign in_ready   = !bus.flush_i && (free_cnt >= CW'(LANES));
    assign write_fire = in_ready && (|bus.in_valid_i);
    assign wr_cnt     = write_fire ? pop_in : '0;

    assign bus.in_ready_o  = in_ready;
    assign bus.count_o     = count_reg;
    assign bus.empty_o     = (count_reg == '0);
    assign bus.full_o      = (free_cnt < CW'(LANES));
    assign bus.out_valid_o = out_valid;
    assign bus.out_instr_o = out_instr;
    assign bus.out_pc_o    = out_pc;
    assign bus.out_imm_o   = out_imm;
    assign bus.out_bp_o    = out_bp;

    // Prefix popcount: lane k lands at slot lane_off[k] of the compacted group.
    always_comb begin
        pop_in = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_off[k] = pop_in;
            if (bus.in_valid_i[k]) pop_in = pop_in + CNT_WIDTH'(1);
        end
    end

`ifdef IBUF_BYPASS_EN
    logic [DATA_WIDTH-1:0] byp_instr [LANES];
    logic [DATA_WIDTH-1:0] byp_pc    [LANES];
    logic [DATA_WIDTH-1:0] byp_imm   [LANES];
    logic                  byp_bp    [LANES];

    assign bypass = write_fire && (count_reg == '0);

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            byp_instr[j] = NOP_INSTR;
            byp_pc[j]    = '0;
            byp_imm[j]   = '0;
            byp_bp[j]    = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                if (bus.in_valid_i[k] && (lane_off[k] == CNT_WIDTH'(j))) begin
                    byp_instr[j] = bus.in_instr_i[k*DATA_WIDTH +: DATA_WIDTH];
                    byp_pc[j]    = bus.in_pc_i[k*DATA_WIDTH +: DATA_WIDTH];
                    byp_imm[j]   = bus.in_imm_i[k*DATA_WIDTH +: DATA_WIDTH];
                    byp_bp[j]    = bus.in_bp_i[k];
                end
            end
        end
    end
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        avail     = '0;
        out_valid = '0;
        out_instr = {LANES{NOP_INSTR}};
        out_pc    = '0;
        out_imm   = '0;
        out_bp    = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef IBUF_BYPASS_EN
            if (bypass) begin
                if (CNT_WIDTH'(k) < wr_cnt) begin
                    out_valid[k]                          = 1'b1;
                    out_instr[k*DATA_WIDTH +: DATA_WIDTH] = byp_instr[k];
                    out_pc[k*DATA_WIDTH +: DATA_WIDTH]    = byp_pc[k];
                    out_imm[k*DATA_WIDTH +: DATA_WIDTH]   = byp_imm[k];
                    out_bp[k]                             = byp_bp[k];
                    avail                                 = avail + CNT_WIDTH'(1);
                end
            end else
`endif
            if (!bus.flush_i && (count_reg > CW'(k))) begin
                out_valid[k]                          = 1'b1;
                out_instr[k*DATA_WIDTH +: DATA_WIDTH] = instr_mem[rptr_reg + ADDR_WIDTH'(k)];
                out_pc[k*DATA_WIDTH +: DATA_WIDTH]    = pc_mem[rptr_reg + ADDR_WIDTH'(k)];
                out_imm[k*DATA_WIDTH +: DATA_WIDTH]   = imm_mem[rptr_reg + ADDR_WIDTH'(k)];
                out_bp[k]                             = bp_mem[rptr_reg + ADDR_WIDTH'(k)];
                avail                                 = avail + CNT_WIDTH'(1);
            end
        end
        rd_cnt = (bus.out_consume_i < avail) ? bus.out_consume_i : avail;
        // Lanes consumed straight off the bypass path are never stored.
        skip   = bypass ? rd_cnt : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_wr
            assign wr_en[gi]   = write_fire && bus.in_valid_i[gi] && (lane_off[gi] >= skip);
            assign wr_addr[gi] = wptr_reg + ADDR_WIDTH'(lane_off[gi]) - ADDR_WIDTH'(skip);
        end
    endgenerate

    always_comb begin
        rptr_next  = rptr_reg;
        wptr_next  = wptr_reg;
        count_next = count_reg;
        if (bus.flush_i) begin
            rptr_next  = '0;
            wptr_next  = '0;
            count_next = '0;
        end else begin
            rptr_next  = rptr_reg + (bypass ? '0 : ADDR_WIDTH'(rd_cnt));
            wptr_next  = wptr_reg + ADDR_WIDTH'(wr_cnt) - ADDR_WIDTH'(skip);
            count_next = count_reg + CW'(wr_cnt) - CW'(rd_cnt);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_reg  <= '0;
            wptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            rptr_reg  <= rptr_next;
            wptr_reg  <= wptr_next;
            count_reg <= count_next;
        end
    end

    // Storage carries no reset; only count decides what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (wr_en[k]) begin
                instr_mem[wr_addr[k]] <= bus.in_instr_i[k*DATA_WIDTH +: DATA_WIDTH];
                pc_mem[wr_addr[k]]    <= bus.in_pc_i[k*DATA_WIDTH +: DATA_WIDTH];
                imm_mem[wr_addr[k]]   <= bus.in_imm_i[k*DATA_WIDTH +: DATA_WIDTH];
                bp_mem[wr_addr[k]]    <= bus.in_bp_i[k];
            end
        end
    end

`ifdef DEBUG
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (count_reg <= CW'(DEPTH));
            assert (bus.out_consume_i <= avail);
        end
    end
`endif
endmodule

// File: tb/tb_multi_lane_instruction_queue.sv
// Directed bench for multi_lane_instruction_queue (LANES=3, DEPTH=16): vector table
// followed by hand-written fill, wrap, flush, bypass and async-reset sequences.
module tb_multi_lane_instruction_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    always #5 clk = ~clk;

    multi_lane_instruction_queue_if #(.LANES(3), .DEPTH(16), .DATA_WIDTH(32)) bus ();

    multi_lane_instruction_queue #(.LANES(3), .DEPTH(16), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0]  valid;
        logic [31:0] base;
        logic [1:0]  consume;
        logic        flush;
        logic [2:0]  exp_valid;
        logic [31:0] exp_i0;
        logic [31:0] exp_i1;
        logic [4:0]  exp_count;
        logic        exp_ready;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else begin
            pass_cnt++;
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [31:0] base,
                         input logic [1:0] cons, input logic fl);
        bus.in_valid_i    = v;
        bus.out_consume_i = cons;
        bus.flush_i       = fl;
        for (int k = 0; k < 3; k++) begin
            bus.in_instr_i[k*32 +: 32] = base + 32'(k);
            bus.in_pc_i[k*32 +: 32]    = base + 32'(k) + 32'h1000;
            bus.in_imm_i[k*32 +: 32]   = ~(base + 32'(k));
            bus.in_bp_i[k]             = base[0] ^ k[0];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] olane(input int k);
        return bus.out_instr_o[k*32 +: 32];
    endfunction

    initial begin
        // A,B,C = 0xA0..; mask 101 compacts A0 and A2.
        vecs[0] = '{3'b000, 32'h0,  2'd0, 1'b0, 3'b000, NOP,  NOP,  5'd0, 1'b1};
        vecs[1] = '{3'b101, 32'hA0, 2'd0, 1'b0, BYP ? 3'b011 : 3'b000,
                    BYP ? 32'hA0 : NOP, BYP ? 32'hA2 : NOP, 5'd0, 1'b1};
        vecs[2] = '{3'b000, 32'h0,  2'd0, 1'b0, 3'b011, 32'hA0, 32'hA2, 5'd2, 1'b1};
        vecs[3] = '{3'b111, 32'hB0, 2'd1, 1'b0, 3'b011, 32'hA0, 32'hA2, 5'd2, 1'b1};
        vecs[4] = '{3'b010, 32'hC0, 2'd3, 1'b0, 3'b111, 32'hA2, 32'hB0, 5'd4, 1'b1};
        vecs[5] = '{3'b000, 32'h0,  2'd2, 1'b0, 3'b011, 32'hB2, 32'hC1, 5'd2, 1'b1};
        vecs[6] = '{3'b000, 32'h0,  2'd0, 1'b0, 3'b000, NOP,  NOP,  5'd0, 1'b1};

        reset = 1'b0;
        drive(3'b000, 32'h0, 2'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 32'(bus.out_valid_o), 32'h0);
        chk("reset in_ready", 32'(bus.in_ready_o), 32'h1);
        chk("reset empty", 32'(bus.empty_o), 32'h1);
        chk("reset full", 32'(bus.full_o), 32'h0);
        chk("reset count", 32'(bus.count_o), 32'h0);
        for (int k = 0; k < 3; k++) chk($sformatf("reset lane%0d nop", k), olane(k), NOP);
        chk("reset pc0", bus.out_pc_o[31:0], 32'h0);
        chk("reset imm0", bus.out_imm_o[31:0], 32'h0);
        chk("reset bp", 32'(bus.out_bp_o), 32'h0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].valid, vecs[i].base, vecs[i].consume, vecs[i].flush);
            @(negedge clk);
            chk($sformatf("v%0d valid", i), 32'(bus.out_valid_o), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d lane0", i), olane(0), vecs[i].exp_i0);
            chk($sformatf("v%0d lane1", i), olane(1), vecs[i].exp_i1);
            chk($sformatf("v%0d count", i), 32'(bus.count_o), 32'(vecs[i].exp_count));
            chk($sformatf("v%0d empty", i), 32'(bus.empty_o), 32'(vecs[i].exp_count == 5'd0));
            chk($sformatf("v%0d ready", i), 32'(bus.in_ready_o), 32'(vecs[i].exp_ready));
            step();
        end

        // Fill: five 3-lane groups reach 15, then a sixth group is refused.
        for (int g = 0; g < 5; g++) begin
            drive(3'b111, 32'h100 * 32'(g + 1), 2'd0, 1'b0);
            step();
        end
        drive(3'b111, 32'h600, 2'd0, 1'b0);
        @(negedge clk);
        chk("fill count", 32'(bus.count_o), 32'd15);
        chk("fill full", 32'(bus.full_o), 32'h1);
        chk("fill in_ready", 32'(bus.in_ready_o), 32'h0);
        step();
        drive(3'b000, 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        chk("drop count", 32'(bus.count_o), 32'd15);
        step();
        for (int d = 0; d < 5; d++) begin
            drive(3'b000, 32'h0, 2'd3, 1'b0);
            @(negedge clk);
            chk($sformatf("drain%0d lane0", d), olane(0), 32'h100 * 32'(d + 1));
            chk($sformatf("drain%0d lane2", d), olane(2), 32'h100 * 32'(d + 1) + 32'd2);
            step();
        end
        drive(3'b000, 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        chk("drain count", 32'(bus.count_o), 32'd0);

        // Wrap: pointers are now 5; move them to 14 then straddle the end.
        for (int g = 0; g < 3; g++) begin
            drive(3'b111, 32'h700 + 32'h10 * 32'(g), 2'd0, 1'b0);
            step();
        end
        for (int g = 0; g < 3; g++) begin
            drive(3'b000, 32'h0, 2'd3, 1'b0);
            step();
        end
        drive(3'b111, 32'hD0, 2'd0, 1'b0);
        step();
        drive(3'b001, 32'hE0, 2'd0, 1'b0);
        step();
        drive(3'b111, 32'hF0, 2'd3, 1'b0);
        @(negedge clk);
        chk("wrap count before", 32'(bus.count_o), 32'd4);
        chk("wrap valid", 32'(bus.out_valid_o), 32'h7);
        chk("wrap lane0 e14", olane(0), 32'hD0);
        chk("wrap lane1 e15", olane(1), 32'hD1);
        chk("wrap lane2 e0", olane(2), 32'hD2);
        chk("wrap pc2", bus.out_pc_o[95:64], 32'h10D2);
        step();
        drive(3'b000, 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        chk("wrap count after", 32'(bus.count_o), 32'd4);
        chk("wrap lane0 e1", olane(0), 32'hE0);
        chk("wrap lane1 e2", olane(1), 32'hF0);
        chk("wrap lane2 e3", olane(2), 32'hF1);
        step();

        // Flush at count 7 with a write and consume pending.
        drive(3'b111, 32'h1200, 2'd0, 1'b0);
        step();
        drive(3'b111, 32'h1300, 2'd2, 1'b1);
        @(negedge clk);
        chk("flush count before", 32'(bus.count_o), 32'd7);
        chk("flush valid", 32'(bus.out_valid_o), 32'h0);
        chk("flush in_ready", 32'(bus.in_ready_o), 32'h0);
        chk("flush lane0 nop", olane(0), NOP);
        step();
        drive(3'b000, 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        chk("post flush count", 32'(bus.count_o), 32'd0);
        chk("post flush empty", 32'(bus.empty_o), 32'h1);
        chk("post flush valid", 32'(bus.out_valid_o), 32'h0);
        step();
        drive(3'b001, 32'h1400, 2'd0, 1'b0);
        step();
        drive(3'b000, 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        chk("refill valid", 32'(bus.out_valid_o), 32'h1);
        chk("refill lane0", olane(0), 32'h1400);
        chk("refill lane1 nop", olane(1), NOP);
        chk("refill count", 32'(bus.count_o), 32'd1);
        step();
        drive(3'b000, 32'h0, 2'd1, 1'b0);
        step();

        // Write into an empty queue while decode asks for two.
        drive(3'b111, 32'h1500, 2'd2, 1'b0);
        @(negedge clk);
        chk("byp valid", 32'(bus.out_valid_o), BYP ? 32'h3 : 32'h0);
        chk("byp lane0", olane(0), BYP ? 32'h1500 : NOP);
        chk("byp lane1", olane(1), BYP ? 32'h1501 : NOP);
        step();
        drive(3'b000, 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        chk("byp next count", 32'(bus.count_o), BYP ? 32'd1 : 32'd3);
        chk("byp next lane0", olane(0), BYP ? 32'h1502 : 32'h1500);

        // Asynchronous reset between clock edges.
        step();
        reset = 1'b0;
        #2;
        chk("async count", 32'(bus.count_o), 32'd0);
        chk("async valid", 32'(bus.out_valid_o), 32'h0);
        chk("async empty", 32'(bus.empty_o), 32'h1);
        chk("async lane0 nop", olane(0), NOP);
        @(negedge clk);
        reset = 1'b1;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
